wb_lfsr_multi: RTL and testbench

Parametrised multi-channel LFSR Wishbone slave, successor to the single-channel 8-bit LFSR peripheral. Provides NCH independent LFSRs of WIDTH bits, each with a programmable tap mask and seed, Fibonacci or Galois mode, free-run or counted stepping, and a per-channel serial bit output. Sits behind the top-level pin wrapper on the same 8-bit pipelined Wishbone bus.

---
 rtl/wb_lfsr_multi.sv | 155 +++++++++++++++
 tb/tb_wb_lfsr_multi.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_lfsr_multi.sv
// Multi-channel LFSR Wishbone slave: NCH channels of WIDTH-bit Fibonacci/Galois LFSRs.
// Optional zero-state recovery with sticky ZERO flag when WB_LFSR_LOCKUP_RECOVER_EN is defined.
module wb_lfsr_multi #(
  parameter int          WIDTH        = 16,
  parameter int          NCH          = 2,
  parameter logic [31:0] DEFAULT_TAPS = 32'h0000B400,
  parameter int          AW           = (NCH > 1) ? 4 + $clog2(NCH) : 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [7:0]      i_wb_data,
  output logic            o_wb_stall,
  output logic [7:0]      o_wb_data,
  output logic            o_wb_ack,
  output logic [NCH-1:0]  o_lfsr_bit
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] r_state [NCH];
  logic [WIDTH-1:0] r_taps  [NCH];
  logic [7:0]       r_step  [NCH];
  logic [NCH-1:0]   r_run;
  logic [NCH-1:0]   r_mode;
  logic [NCH-1:0]   r_bit;
  logic             r_ack;
  logic [7:0]       r_rdata;
`ifdef WB_LFSR_LOCKUP_RECOVER_EN
  logic [NCH-1:0]   r_zero;
`endif

  logic [7:0]       w_addr_x;
  logic [3:0]       w_reg;
  logic [3:0]       w_ch;
  logic             w_cfg_reg;
  logic             w_busy_sel;
  logic             w_stall;
  logic             w_acc;
  logic             w_wr;
  logic [7:0]       w_rdata;
  logic [NCH-1:0]   w_zero;
  logic [NCH-1:0]   w_hit;
  logic [NCH-1:0]   w_blk;
  logic [NCH-1:0]   w_adv;
  logic [WIDTH-1:0] w_nxt [NCH];

  assign w_addr_x  = 8'(i_wb_addr);
  assign w_reg     = w_addr_x[3:0];
  assign w_ch      = w_addr_x[7:4];
  assign w_cfg_reg = (w_reg < 4'(NB)) || ((w_reg >= 4'd4) && (w_reg < 4'(4 + NB))) ||
                     (w_reg == 4'd8);

  // Decode, read mux and next-state per channel; an out-of-range channel matches nothing.
  always_comb begin
    w_rdata    = 8'h00;
    w_busy_sel = 1'b0;
    w_zero     = '0;
    for (int c = 0; c < NCH; c++) begin
`ifdef WB_LFSR_LOCKUP_RECOVER_EN
      w_zero[c] = r_zero[c];
`else
      w_zero[c] = (r_state[c] == '0);
`endif
      w_nxt[c] = r_mode[c] ? ((r_state[c] >> 1) ^ (r_state[c][0] ? r_taps[c] : '0))
                           : {r_state[c][WIDTH-2:0], ^(r_state[c] & r_taps[c])};
      if (w_ch == 4'(c)) begin
        w_busy_sel = (r_step[c] != 8'd0);
        for (int k = 0; k < NB; k++) begin
          if (w_reg == 4'(k))     w_rdata = r_state[c][8*k +: 8];
          if (w_reg == 4'(4 + k)) w_rdata = r_taps[c][8*k +: 8];
        end
        if (w_reg == 4'd8)  w_rdata = {6'd0, r_mode[c], r_run[c]};
        if (w_reg == 4'd9)  w_rdata = r_step[c];
        if (w_reg == 4'd10) w_rdata = {6'd0, w_zero[c], w_busy_sel};
      end
    end
  end

  assign w_stall = i_wb_cyc & i_wb_stb & i_wb_we & (w_reg <= 4'd9) & w_busy_sel;
  assign w_acc   = i_wb_cyc & i_wb_stb & ~w_stall;
  assign w_wr    = w_acc & i_wb_we;

  // A config write to STATE/TAPS/CTRL wins over that cycle's advance.
  always_comb begin
    w_hit = '0;
    w_blk = '0;
    w_adv = '0;
    for (int c = 0; c < NCH; c++) begin
      w_hit[c] = w_wr && (w_ch == 4'(c));
      w_blk[c] = w_hit[c] && w_cfg_reg;
      w_adv[c] = (r_run[c] || (r_step[c] != 8'd0)) && !w_blk[c];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ack   <= 1'b0;
      r_rdata <= 8'h00;
      r_run   <= '0;
      r_mode  <= '0;
      r_bit   <= '0;
`ifdef WB_LFSR_LOCKUP_RECOVER_EN
      r_zero  <= '0;
`endif
      for (int c = 0; c < NCH; c++) begin
        r_state[c] <= WIDTH'(1);
        r_taps[c]  <= DEFAULT_TAPS[WIDTH-1:0];
        r_step[c]  <= 8'd0;
      end
    end else begin
      r_ack   <= w_acc;
      r_rdata <= (w_acc && !i_wb_we) ? w_rdata : 8'h00;
      for (int c = 0; c < NCH; c++) begin
        r_bit[c] <= r_mode[c] ? r_state[c][0] : r_state[c][WIDTH-1];
        if (w_adv[c]) begin
`ifdef WB_LFSR_LOCKUP_RECOVER_EN
          if (r_state[c] == '0) begin
            r_state[c] <= WIDTH'(1);
            r_zero[c]  <= 1'b1;
          end else begin
            r_state[c] <= w_nxt[c];
          end
`else
          r_state[c] <= w_nxt[c];
`endif
          if (r_step[c] != 8'd0) r_step[c] <= r_step[c] - 8'd1;
        end
        if (w_hit[c]) begin
          for (int k = 0; k < NB; k++) begin
            if (w_reg == 4'(k))     r_state[c][8*k +: 8] <= i_wb_data;
            if (w_reg == 4'(4 + k)) r_taps[c][8*k +: 8]  <= i_wb_data;
          end
          if (w_reg == 4'd8) begin
            r_run[c]  <= i_wb_data[0];
            r_mode[c] <= i_wb_data[1];
          end
          if (w_reg == 4'd9) r_step[c] <= i_wb_data;
`ifdef WB_LFSR_LOCKUP_RECOVER_EN
          if ((w_reg == 4'd10) && !(w_adv[c] && (r_state[c] == '0))) r_zero[c] <= 1'b0;
`endif
        end
      end
    end
  end

  assign o_wb_stall = w_stall;
  assign o_wb_ack   = r_ack & i_wb_cyc;
  assign o_wb_data  = o_wb_ack ? r_rdata : 8'h00;
  assign o_lfsr_bit = r_bit;

endmodule

// File: tb/tb_wb_lfsr_multi.sv
// Self-checking bench for wb_lfsr_multi: register-level reference model compared every cycle,
// plus directed bus transactions with literal expected values.
module tb_wb_lfsr_multi;
  localparam int          WIDTH = 16;
  localparam int          NCH   = 2;
  localparam int          NB    = WIDTH / 8;
  localparam logic [31:0] DTAPS = 32'h0000B400;
  localparam logic [31:0] MASK  = (WIDTH == 32) ? 32'hFFFF_FFFF : ((32'h1 << WIDTH) - 32'h1);
`ifdef WB_LFSR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_wb_cyc = 1'b0;
  logic           i_wb_stb = 1'b0;
  logic           i_wb_we = 1'b0;
  logic [4:0]     i_wb_addr = '0;
  logic [7:0]     i_wb_data = '0;
  logic           o_wb_stall;
  logic [7:0]     o_wb_data;
  logic           o_wb_ack;
  logic [NCH-1:0] o_lfsr_bit;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_lfsr_multi #(.WIDTH(WIDTH), .NCH(NCH), .DEFAULT_TAPS(DTAPS)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data), .o_wb_ack(o_wb_ack),
    .o_lfsr_bit(o_lfsr_bit)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]    m_st   [NCH];
  logic [31:0]    m_tp   [NCH];
  logic [7:0]     m_step [NCH];
  logic           m_run  [NCH];
  logic           m_mode [NCH];
  logic           m_zs   [NCH];
  logic           m_ack = 1'b0;
  logic [7:0]     m_data = '0;
  logic [NCH-1:0] m_bit = '0;
  bit             m_valid = 1'b0;

  function automatic logic m_zero(input int c);
    return RECOVER ? m_zs[c] : (m_st[c] == 32'd0);
  endfunction

  function automatic logic [7:0] m_read(input int ch, input int r);
    logic [7:0] v = 8'h00;
    if (ch >= NCH) return 8'h00;
    if (r < NB)                v = 8'((m_st[ch] >> (8 * r)) & 32'hFF);
    else if (r >= 4 && r < 4 + NB) v = 8'((m_tp[ch] >> (8 * (r - 4))) & 32'hFF);
    else if (r == 8)           v = {6'd0, m_mode[ch], m_run[ch]};
    else if (r == 9)           v = m_step[ch];
    else if (r == 10)          v = {6'd0, m_zero(ch), m_step[ch] != 8'd0};
    return v;
  endfunction

  function automatic logic m_stall();
    int ch = int'(i_wb_addr[4]);
    int r  = int'(i_wb_addr[3:0]);
    return i_wb_cyc && i_wb_stb && i_wb_we && (r <= 9) && (ch < NCH) && (m_step[ch] != 8'd0);
  endfunction

  task automatic model_step();
    int ch = int'(i_wb_addr[4]);
    int r  = int'(i_wb_addr[3:0]);
    logic acc, hit, cfgw, setz;
    logic [NCH-1:0] nb;
    if (i_reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_st[c] = 32'd1; m_tp[c] = DTAPS & MASK; m_step[c] = 8'd0;
        m_run[c] = 1'b0; m_mode[c] = 1'b0; m_zs[c] = 1'b0;
      end
      m_ack = 1'b0; m_data = 8'h00; m_bit = '0;
      return;
    end
    acc    = i_wb_cyc && i_wb_stb && !m_stall();
    m_ack  = acc;
    m_data = (acc && !i_wb_we) ? m_read(ch, r) : 8'h00;
    for (int c = 0; c < NCH; c++) nb[c] = m_mode[c] ? m_st[c][0] : m_st[c][WIDTH-1];
    for (int c = 0; c < NCH; c++) begin
      hit  = acc && i_wb_we && (ch == c);
      cfgw = hit && ((r < NB) || (r >= 4 && r < 4 + NB) || (r == 8));
      setz = 1'b0;
      if (!cfgw && (m_run[c] || m_step[c] != 8'd0)) begin
        if (m_st[c] == 32'd0 && RECOVER) begin
          m_st[c] = 32'd1; m_zs[c] = 1'b1; setz = 1'b1;
        end else if (m_mode[c]) begin
          m_st[c] = (m_st[c] >> 1) ^ (m_st[c][0] ? m_tp[c] : 32'd0);
        end else begin
          m_st[c] = ((m_st[c] << 1) | 32'($countones(m_st[c] & m_tp[c]) % 2)) & MASK;
        end
        if (m_step[c] != 8'd0) m_step[c] = m_step[c] - 8'd1;
      end
      if (hit) begin
        if (r < NB)
          m_st[c] = (m_st[c] & ~(32'hFF << (8 * r))) | (32'(i_wb_data) << (8 * r));
        else if (r >= 4 && r < 4 + NB)
          m_tp[c] = (m_tp[c] & ~(32'hFF << (8 * (r - 4)))) | (32'(i_wb_data) << (8 * (r - 4)));
        else if (r == 8) begin
          m_run[c] = i_wb_data[0]; m_mode[c] = i_wb_data[1];
        end else if (r == 9) m_step[c] = i_wb_data;
        else if (r == 10 && RECOVER && !setz) m_zs[c] = 1'b0;
      end
    end
    m_bit = nb;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      if (i_reset) m_valid = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("cyc_ack",   32'(o_wb_ack),   32'(m_ack & i_wb_cyc));
        check("cyc_data",  32'(o_wb_data),  32'((m_ack & i_wb_cyc) ? m_data : 8'h00));
        check("cyc_stall", 32'(o_wb_stall), 32'(m_stall()));
        check("cyc_bit",   32'(o_lfsr_bit), 32'(m_bit));
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_read(input logic [4:0] a, input int exp, input string name);
    @(posedge clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
    @(posedge clk); #1;
    i_wb_stb = 1'b0;
    @(negedge clk);
    check({name, "_ack"}, 32'(o_wb_ack), 32'd1);
    if (exp >= 0) check(name, 32'(o_wb_data), 32'(exp));
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [7:0] d, output int stalls);
    logic s;
    @(posedge clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    stalls = 0;
    forever begin
      @(negedge clk);
      s = o_wb_stall;
      @(posedge clk);
      if (!s) break;
      stalls++;
      if (stalls > 300) begin
        check("write_stall_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
    #1;
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    int s;
    wb_write(a, d, s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0; i_wb_cyc = 1'b1;
    @(negedge clk);
    check("rst_ack", 32'(o_wb_ack), 32'd0);
    check("rst_stall", 32'(o_wb_stall), 32'd0);
    check("rst_bit", 32'(o_lfsr_bit), 32'd0);

    wb_read(5'h00, 8'h01, "rst_state0");
    wb_read(5'h01, 8'h00, "rst_state1");
    wb_read(5'h04, 8'h00, "rst_taps0");
    wb_read(5'h05, 8'hB4, "rst_taps1");
    wb_read(5'h0A, 8'h00, "rst_status");

    // back-to-back reads
    @(posedge clk); #1;
    i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 5'h15;
    @(posedge clk); #1;
    i_wb_addr = 5'h00;
    @(negedge clk);
    check("b2b_first", 32'(o_wb_data), 32'hB4);
    @(posedge clk); #1;
    i_wb_stb = 1'b0;
    @(negedge clk);
    check("b2b_second", 32'(o_wb_data), 32'h01);

    // ch0 Galois, two counted steps
    wr(5'h00, 8'h01);
    wr(5'h08, 8'h02);
    wb_write(5'h09, 8'h02, st);
    check("galois_step_nostall", 32'(st), 32'd0);
    repeat (4) @(posedge clk);
    wb_read(5'h01, 8'h5A, "galois_state1");
    wb_read(5'h00, 8'h00, "galois_state0");
    wb_read(5'h0A, 8'h00, "galois_status");
    repeat (6) @(posedge clk);
    wb_read(5'h01, 8'h5A, "galois_hold");

    // ch1 Fibonacci, one step
    wr(5'h10, 8'h00);
    wr(5'h11, 8'h80);
    wr(5'h19, 8'h01);
    repeat (3) @(posedge clk);
    wb_read(5'h10, 8'h01, "fib_state0");
    wb_read(5'h11, 8'h00, "fib_state1");
    wb_read(5'h01, 8'h5A, "fib_ch0_untouched");

    // busy stall
    wb_write(5'h09, 8'h05, st);
    check("step5_nostall", 32'(st), 32'd0);
    wb_read(5'h0A, 8'h01, "busy_status");
    wb_write(5'h00, 8'h00, st);
    check("busy_write_stalled", 32'(st > 0), 32'd1);
    wb_read(5'h0A, 8'h00, "busy_done_status");

    // zero-state lockup
    wr(5'h00, 8'h00);
    wr(5'h01, 8'h00);
    wr(5'h08, 8'h01);
    wb_read(5'h0A, 8'h02, "zero_status");
    if (RECOVER) begin
      wr(5'h0A, 8'h00);
      wb_read(5'h0A, 8'h00, "zero_cleared");
    end else begin
      wb_read(5'h00, 8'h00, "zero_lock_state0");
      wb_read(5'h01, 8'h00, "zero_lock_state1");
    end
    wr(5'h08, 8'h00);

    // ch1 free run then stop
    wr(5'h18, 8'h01);
    repeat (12) @(posedge clk);
    wr(5'h18, 8'h00);
    wr(5'h18, 8'h03);
    repeat (9) @(posedge clk);
    wr(5'h18, 8'h00);

    // reserved locations
    wb_read(5'h0C, 8'h00, "rsv_reg12");
    wb_read(5'h02, 8'h00, "rsv_state2");
    wb_read(5'h1F, 8'h00, "rsv_ch1_reg15");
    wr(5'h0C, 8'hFF);
    wb_read(5'h0C, 8'h00, "rsv_write_ignored");

    // cyc dropped in the ack cycle
    @(posedge clk); #1;
    i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 5'h05;
    @(posedge clk); #1;
    i_wb_stb = 1'b0; i_wb_cyc = 1'b0;
    @(negedge clk);
    check("cyc_drop_ack", 32'(o_wb_ack), 32'd0);
    @(posedge clk); #1;
    i_wb_cyc = 1'b1;

    // reset mid-transaction
    wr(5'h15, 8'h12);
    wr(5'h09, 8'h40);
    @(posedge clk); #1;
    i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 5'h00; i_reset = 1'b1;
    @(posedge clk); #1;
    i_wb_stb = 1'b0; i_reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ack", 32'(o_wb_ack), 32'd0);
    wb_read(5'h15, 8'hB4, "rst_mid_taps1");
    wb_read(5'h0A, 8'h00, "rst_mid_status");
    wb_read(5'h00, 8'h01, "rst_mid_state0");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
